// File: rtl/dsound_fifo.sv
// Direct-sound sample FIFO: 32-bit or paired 16-bit bus writes in, show-ahead word out; pushes/pops visible next cycle.
// No backpressure: a push into a full FIFO without a same-cycle pop is dropped and flagged by a one-cycle overflow pulse.
module dsound_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             wr_en,
    input  logic             wr_half,
    input  logic             wr_hi,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             fifo_re,
    input  logic             fifo_clr,
    output logic [WIDTH-1:0] fifo_val,
    output logic [SW-1:0]    fifo_size,
    output logic             fifo_full,
    output logic             overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int HW = WIDTH / 2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [SW-1:0]    count;
    logic [HW-1:0]    hold_lo;
    logic             hold_valid;

    logic             full, empty, push, pop, wr_ok;
    logic [WIDTH-1:0] push_dat;

    always_comb begin
        full  = (count == SW'(DEPTH));
        empty = (count == '0);
        push  = wr_en & (~wr_half | wr_hi);
        pop   = fifo_re & ~empty;
        // When full, a same-cycle pop frees the slot the push lands in.
        wr_ok = push & (~full | pop);
        if (wr_half)
            push_dat = {wr_data[HW-1:0], (hold_valid ? hold_lo : HW'(0))};
        else
            push_dat = wr_data;
    end

    always_ff @(posedge clk) begin
        if (~fifo_clr && wr_ok)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hold_lo    <= '0;
            hold_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (fifo_clr) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hold_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= push & full & ~pop;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en) begin
                if (wr_half && !wr_hi) begin
                    hold_lo    <= wr_data[HW-1:0];
                    hold_valid <= 1'b1;
                end else begin
                    hold_valid <= 1'b0;
                end
            end
        end
    end

    assign fifo_val  = empty ? '0 : mem[rd_ptr];
    assign fifo_size = count;
    assign fifo_full = full;
endmodule

// File: tb/tb_dsound_fifo.sv
// Randomized and directed stimulus for dsound_fifo, checked every cycle against a queue-based model.
module tb_dsound_fifo;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        wr_en = 1'b0, wr_half = 1'b0, wr_hi = 1'b0;
    logic [31:0] wr_data = '0;
    logic        fifo_re = 1'b0, fifo_clr = 1'b0;
    logic [31:0] fifo_val;
    logic [3:0]  fifo_size;
    logic        fifo_full, overflow;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mq[$];
    logic        m_hv = 1'b0;
    logic [15:0] m_lo = '0;
    logic        m_ov = 1'b0;

    dsound_fifo #(.DEPTH(DEPTH), .WIDTH(32), .SW(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .wr_en(wr_en), .wr_half(wr_half), .wr_hi(wr_hi), .wr_data(wr_data),
        .fifo_re(fifo_re), .fifo_clr(fifo_clr),
        .fifo_val(fifo_val), .fifo_size(fifo_size), .fifo_full(fifo_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic we, hf, hi, input logic [31:0] d,
                              input logic re, cl);
        logic        do_push;
        logic [31:0] w;
        m_ov = 1'b0;
        if (cl) begin
            mq.delete();
            m_hv = 1'b0;
        end else begin
            do_push = we && (!hf || hi);
            w = !hf ? d : {d[15:0], (m_hv ? m_lo : 16'h0)};
            if (re && mq.size() > 0)
                void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(w);
                else m_ov = 1'b1;
            end
            if (we) begin
                if (hf && !hi) begin
                    m_lo = d[15:0];
                    m_hv = 1'b1;
                end else begin
                    m_hv = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_size"}, 32'(fifo_size), 32'(mq.size()));
        chk({tag, "_full"}, 32'(fifo_full), 32'(mq.size() == DEPTH));
        chk({tag, "_ovf"},  32'(overflow),  32'(m_ov));
        chk({tag, "_val"},  fifo_val, (mq.size() > 0) ? mq[0] : 32'h0);
    endtask

    task automatic cyc(input string tag, input logic we, hf, hi, input logic [31:0] d,
                       input logic re, cl);
        wr_en = we; wr_half = hf; wr_hi = hi; wr_data = d;
        fifo_re = re; fifo_clr = cl;
        @(posedge clk);
        model_step(we, hf, hi, d, re, cl);
        #1;
        wr_en = 1'b0; wr_half = 1'b0; wr_hi = 1'b0; fifo_re = 1'b0; fifo_clr = 1'b0;
        check_all(tag);
    endtask

    task automatic w32(input logic [31:0] d); cyc("w32", 1, 0, 0, d, 0, 0); endtask
    task automatic pop1(); cyc("pop", 0, 0, 0, 32'h0, 1, 0); endtask

    initial begin
        #2;
        check_all("reset");
        #10 rst_b = 1'b1;
        @(posedge clk); #1;

        // Fill to full, then drain in order.
        for (int i = 1; i <= 8; i++) w32(32'h11111111 * i);
        chk("p1_full", 32'(fifo_full), 32'h1);
        chk("p1_head", fifo_val, 32'h11111111);
        for (int i = 0; i < 8; i++) pop1();
        chk("p1_empty_val", fifo_val, 32'h0);

        // Halfword pairing and lone upper half.
        cyc("lo", 1, 1, 0, 32'h0000BEEF, 0, 0);
        chk("p2_nopush", 32'(fifo_size), 32'h0);
        cyc("hi", 1, 1, 1, 32'h0000DEAD, 0, 0);
        chk("p2_pair", fifo_val, 32'hDEADBEEF);
        pop1();
        cyc("hi_lone", 1, 1, 1, 32'h00001234, 0, 0);
        chk("p2_lone", fifo_val, 32'h12340000);
        pop1();

        // Overflow when full; push+pop when full does not overflow.
        for (int i = 0; i < 8; i++) w32(32'hA0000000 + i);
        w32(32'h99999999);
        chk("p3_ovf_pulse", 32'(overflow), 32'h1);
        cyc("idle", 0, 0, 0, 32'h0, 0, 0);
        chk("p3_ovf_drop", 32'(overflow), 32'h0);
        cyc("wr_pop_full", 1, 0, 0, 32'h99999999, 1, 0);
        chk("p3_no_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 7; i++) pop1();
        chk("p3_tail", fifo_val, 32'h99999999);
        pop1();

        // Empty FIFO: push+pop together, then lone pop.
        cyc("wr_pop_empty", 1, 0, 0, 32'hCAFEF00D, 1, 0);
        chk("p4_val", fifo_val, 32'hCAFEF00D);
        pop1();
        pop1();
        chk("p4_empty", 32'(fifo_size), 32'h0);

        // Flush beats a same-cycle push and pop, and drops the held half.
        for (int i = 0; i < 5; i++) w32(32'h50000000 + i);
        cyc("lo", 1, 1, 0, 32'h00005555, 0, 0);
        cyc("clr", 1, 0, 0, 32'h77777777, 1, 1);
        chk("p5_size", 32'(fifo_size), 32'h0);
        cyc("hi_after_clr", 1, 1, 1, 32'h0000AAAA, 0, 0);
        chk("p5_hold_clr", fifo_val, 32'hAAAA0000);
        pop1();

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) w32(32'hC0000000 + i);
        cyc("lo", 1, 1, 0, 32'h00001111, 0, 0);
        #2 rst_b = 1'b0;
        #1;
        mq.delete(); m_hv = 1'b0; m_ov = 1'b0;
        chk("arst_size", 32'(fifo_size), 32'h0);
        chk("arst_val", fifo_val, 32'h0);
        chk("arst_full", 32'(fifo_full), 32'h0);
        chk("arst_ovf", 32'(overflow), 32'h0);
        @(negedge clk) rst_b = 1'b1;
        @(posedge clk); #1;
        cyc("hi_after_rst", 1, 1, 1, 32'h00002222, 0, 0);
        chk("arst_hold", fifo_val, 32'h22220000);
        pop1();

        // Pointer wrap across 20 overlapping pushes and pops.
        w32(32'hD0000000);
        for (int i = 1; i < 20; i++) cyc("wrap", 1, 0, 0, 32'hD0000000 + i, 1, 0);
        chk("wrap_head", fifo_val, 32'hD0000013);
        pop1();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic we, hf, hi, re, cl;
            we = ($urandom_range(0, 99) < 55);
            hf = ($urandom_range(0, 99) < 40);
            hi = $urandom_range(0, 1) == 1;
            re = ($urandom_range(0, 99) < 45);
            cl = ($urandom_range(0, 99) < 2);
            cyc("rnd", we, hf, hi, $urandom, re, cl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
